// File: rtl/jump_input_ctl.sv
// jump_input_ctl: turns raw space/left/right key levels into walk steps and
// a single charged jump request for the character datapath.
// Keys are synchronised and debounced, then arbitrated by a five-state FSM
// (IDLE, WALK, CHARGE, LAUNCH, AIR) whose state is visible on ctl_state.
// Optional build macro: JUMP_AUTO_RELEASE_EN launches automatically once the
// charge counter has saturated at MAX_POWER.
// Handshake note: step_left/step_right/jump_req are single-cycle pulses with
// no back-pressure; the datapath acknowledges a launch only by leaving the
// grounded character_state (00) while the FSM waits in LAUNCH.
module jump_input_ctl #(
  parameter int PWR_W        = 6,
  parameter int MAX_POWER    = 63,
  parameter int MIN_POWER    = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_space,
  input  logic             key_left,
  input  logic             key_right,
  input  logic             frame_tick,
  input  logic [1:0]       character_state,
  output logic             step_left,
  output logic             step_right,
  output logic             jump_req,
  output logic [PWR_W-1:0] jump_power,
  output logic [1:0]       jump_dir,
  output logic             charging,
  output logic [2:0]       ctl_state
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);
  localparam logic [PWR_W-1:0] MAX_P    = PWR_W'(MAX_POWER);
  localparam logic [PWR_W-1:0] MIN_P    = PWR_W'(MIN_POWER);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WALK   = 3'd1,
    S_CHARGE = 3'd2,
    S_LAUNCH = 3'd3,
    S_AIR    = 3'd4
  } state_t;

  // key vectors: bit 2 = space, bit 1 = left, bit 0 = right
  logic [2:0]       r_sync1;
  logic [2:0]       r_sync2;
  logic [2:0]       r_db;
  logic [DB_W-1:0]  r_db_cnt [3];

  state_t           r_state;
  logic [PWR_W-1:0] r_charge;
  logic [TMO_W-1:0] r_tmo;
  logic             r_armed;

  state_t           w_state_nxt;
  logic [PWR_W-1:0] w_charge_nxt;
  logic [PWR_W-1:0] w_charge_inc;
  logic [PWR_W-1:0] w_launch_cnt;
  logic [TMO_W-1:0] w_tmo_nxt;
  logic             w_armed_nxt;
  logic [PWR_W-1:0] w_power_nxt;
  logic [1:0]       w_dir_nxt;
  logic             w_step_l;
  logic             w_step_r;
  logic             w_jreq;
  logic             w_space;
  logic [1:0]       w_dir;
  logic             w_grounded;
  logic             w_release;
  logic             w_step_ok;

  // two-flop synchroniser for the asynchronous key levels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {key_space, key_left, key_right};
      r_sync2 <= r_sync1;
    end
  end

  // per-key debounce: accept a new level after DEBOUNCE_CYC stable cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_db <= '0;
      for (int i = 0; i < 3; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (r_sync2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_db[i]     <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_space    = r_db[2];
  assign w_dir      = {r_db[0] & ~r_db[1], r_db[1] & ~r_db[0]};
  assign w_grounded = (character_state == 2'b00);
  assign w_charge_inc = (r_charge == MAX_P) ? r_charge : r_charge + 1'b1;
  // a tick on the release cycle still counts toward the launched power
  assign w_launch_cnt = frame_tick ? w_charge_inc : r_charge;
  // never emit a step on two consecutive cycles
  assign w_step_ok  = frame_tick & ~step_left & ~step_right;

`ifdef JUMP_AUTO_RELEASE_EN
  assign w_release = ~w_space | (r_charge == MAX_P);
`else
  assign w_release = ~w_space;
`endif

  // next-state and next-output logic for the control FSM
  always_comb begin
    w_state_nxt  = r_state;
    w_charge_nxt = r_charge;
    w_tmo_nxt    = r_tmo;
    w_armed_nxt  = r_armed | ~w_space;
    w_power_nxt  = jump_power;
    w_dir_nxt    = jump_dir;
    w_step_l     = 1'b0;
    w_step_r     = 1'b0;
    w_jreq       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_space && r_armed && w_grounded) begin
          w_state_nxt  = S_CHARGE;
          w_charge_nxt = '0;
        end else if (w_dir != 2'b00 && w_grounded) begin
          w_state_nxt = S_WALK;
        end else if (!w_grounded) begin
          w_state_nxt = S_AIR;
        end
      end
      S_WALK: begin
        if (!w_grounded) begin
          w_state_nxt = S_AIR;
        end else if (w_space && r_armed) begin
          w_state_nxt  = S_CHARGE;
          w_charge_nxt = '0;
        end else if (w_dir == 2'b00) begin
          w_state_nxt = S_IDLE;
        end else if (w_step_ok) begin
          w_step_l = w_dir[0];
          w_step_r = w_dir[1];
        end
      end
      S_CHARGE: begin
        w_dir_nxt = w_dir;
        if (!w_grounded) begin
          w_state_nxt  = S_AIR;
          w_charge_nxt = '0;
        end else if (w_release) begin
          w_state_nxt  = S_LAUNCH;
          w_charge_nxt = w_launch_cnt;
          w_power_nxt  = (w_launch_cnt < MIN_P) ? MIN_P : w_launch_cnt;
          w_jreq       = 1'b1;
          w_armed_nxt  = 1'b0;
          w_tmo_nxt    = '0;
        end else if (frame_tick) begin
          w_charge_nxt = w_charge_inc;
        end
      end
      S_LAUNCH: begin
        if (!w_grounded) begin
          w_state_nxt = S_AIR;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_tmo_nxt = r_tmo + 1'b1;
        end
      end
      S_AIR: begin
        if (w_space) w_armed_nxt = 1'b0;
        if (w_grounded) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_charge   <= '0;
      r_tmo      <= '0;
      r_armed    <= 1'b1;
      step_left  <= 1'b0;
      step_right <= 1'b0;
      jump_req   <= 1'b0;
      jump_power <= '0;
      jump_dir   <= 2'b00;
      charging   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_charge   <= w_charge_nxt;
      r_tmo      <= w_tmo_nxt;
      r_armed    <= w_armed_nxt;
      step_left  <= w_step_l;
      step_right <= w_step_r;
      jump_req   <= w_jreq;
      jump_power <= w_power_nxt;
      jump_dir   <= w_dir_nxt;
      charging   <= (w_state_nxt == S_CHARGE);
    end
  end

  assign ctl_state = r_state;

endmodule

// File: tb/tb_jump_input_ctl.sv
// tb_jump_input_ctl: directed and randomized checks of jump_input_ctl.
// Expected jump power/direction and step counts come from a small rule model
// (power = clamp(ticks, MIN_POWER, MAX_POWER); direction from the held keys).
module tb_jump_input_ctl;

  localparam int PWR_W = 6;

  logic             clk;
  logic             rst;
  logic             key_space;
  logic             key_left;
  logic             key_right;
  logic             frame_tick;
  logic [1:0]       character_state;
  logic             step_left;
  logic             step_right;
  logic             jump_req;
  logic [PWR_W-1:0] jump_power;
  logic [1:0]       jump_dir;
  logic             charging;
  logic [2:0]       ctl_state;

  int total = 0;
  int bad   = 0;

  // pulse bookkeeping written only by the monitor
  int n_sl = 0;
  int n_sr = 0;
  int n_jump = 0;
  int n_chg = 0;
  int viol = 0;
  logic prev_pulse = 1'b0;
  logic [PWR_W-1:0] cap_pow = '0;
  logic [1:0] cap_dir = '0;

  jump_input_ctl dut (
    .clk(clk), .rst(rst), .key_space(key_space), .key_left(key_left),
    .key_right(key_right), .frame_tick(frame_tick),
    .character_state(character_state), .step_left(step_left),
    .step_right(step_right), .jump_req(jump_req), .jump_power(jump_power),
    .jump_dir(jump_dir), .charging(charging), .ctl_state(ctl_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // monitor: count pulses and catch overlapping or back-to-back pulses
  always @(negedge clk) begin
    if (rst) begin
      if (step_left) n_sl++;
      if (step_right) n_sr++;
      if (charging) n_chg++;
      if ((int'(step_left) + int'(step_right) + int'(jump_req)) > 1) viol++;
      if ((step_left | step_right | jump_req) && prev_pulse) viol++;
      prev_pulse = step_left | step_right | jump_req;
      if (jump_req) begin
        cap_pow = jump_power;
        cap_dir = jump_dir;
        n_jump++;
      end
    end else begin
      prev_pulse = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(2);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (ctl_state == target) break;
      cyc(1);
    end
    check(tag, 32'(ctl_state), 32'(target));
  endtask

  task automatic wait_jumps(input string tag, input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (n_jump >= target) break;
      cyc(1);
    end
    check(tag, n_jump, target);
  endtask

  // charge for n ticks with the given direction keys, launch, fly and land
  task automatic do_jump(input string tag, input int n, input logic l, input logic r);
    int base;
    int exp_pow;
    int exp_dir;
    base = n_jump;
    exp_pow = (n > 63) ? 63 : n;
    if (exp_pow < 4) exp_pow = 4;
    exp_dir = (l && !r) ? 1 : ((r && !l) ? 2 : 0);
    key_left  = l;
    key_right = r;
    key_space = 1'b1;
    wait_state({tag, "_charge"}, 3'd2, 40);
    for (int i = 0; i < n; i++) frame();
    key_space = 1'b0;
    wait_jumps({tag, "_req"}, base + 1, 40);
    check({tag, "_power"}, 32'(cap_pow), exp_pow);
    check({tag, "_dir"}, 32'(cap_dir), exp_dir);
    key_left  = 1'b0;
    key_right = 1'b0;
    character_state = 2'b01;
    wait_state({tag, "_air"}, 3'd4, 10);
    character_state = 2'b00;
    wait_state({tag, "_land"}, 3'd0, 10);
    cyc(12);
  endtask

  task automatic do_walk(input string tag, input int n, input logic l);
    int bl;
    int br;
    key_left  = l;
    key_right = ~l;
    wait_state({tag, "_walk"}, 3'd1, 30);
    bl = n_sl;
    br = n_sr;
    for (int i = 0; i < n; i++) frame();
    check({tag, "_steps_l"}, n_sl - bl, l ? n : 0);
    check({tag, "_steps_r"}, n_sr - br, l ? 0 : n);
    key_left  = 1'b0;
    key_right = 1'b0;
    wait_state({tag, "_idle"}, 3'd0, 30);
  endtask

  initial begin
    int base;
    int c0;
    int bl;
    int br;
    rst = 1'b0;
    key_space = 1'b0;
    key_left = 1'b0;
    key_right = 1'b0;
    frame_tick = 1'b0;
    character_state = 2'b00;

    // reset state
    cyc(3);
    check("rst_state", 32'(ctl_state), 0);
    check("rst_outs", 32'({step_left, step_right, jump_req, jump_power, jump_dir, charging}), 0);
    rst = 1'b1;

    // latency: space held from here; charging appears on the 7th edge
    key_space = 1'b1;
    cyc(6);
    check("lat_not_yet", 32'(charging), 0);
    cyc(1);
    check("lat_charging", 32'(charging), 1);
    check("lat_state", 32'(ctl_state), 2);
    do_jump("min0", 0, 1'b0, 1'b0);

    // 3-cycle glitch must be rejected
    c0 = n_chg;
    key_space = 1'b1;
    cyc(3);
    key_space = 1'b0;
    cyc(20);
    check("glitch_state", 32'(ctl_state), 0);
    check("glitch_chg", n_chg - c0, 0);

    // directed jumps
    do_jump("right10", 10, 1'b0, 1'b1);
    do_jump("min2", 2, 1'b0, 1'b0);
    do_jump("sat100", 100, 1'b1, 1'b0);
    do_jump("both", 7, 1'b1, 1'b1);

    // randomized jumps
    for (int k = 0; k < 5; k++) begin
      int n;
      n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(60, 70)) : int'($urandom_range(0, 12));
      do_jump($sformatf("rj%0d", k), n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // walking left 5 ticks, then both keys stops walking
    key_left = 1'b1;
    wait_state("walk_l", 3'd1, 30);
    bl = n_sl;
    br = n_sr;
    for (int i = 0; i < 5; i++) frame();
    check("walk5_l", n_sl - bl, 5);
    check("walk5_r", n_sr - br, 0);
    key_right = 1'b1;
    cyc(12);
    check("both_idle", 32'(ctl_state), 0);
    bl = n_sl;
    br = n_sr;
    for (int i = 0; i < 3; i++) frame();
    check("both_nostep", (n_sl - bl) + (n_sr - br), 0);
    key_left = 1'b0;
    key_right = 1'b0;
    cyc(12);

    // randomized walks
    for (int k = 0; k < 3; k++) begin
      do_walk($sformatf("rw%0d", k), int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)));
    end

    // launch without acknowledge times out after 1024 cycles
    key_space = 1'b1;
    wait_state("tmo_charge", 3'd2, 40);
    for (int i = 0; i < 5; i++) frame();
    key_space = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (jump_req) break;
      cyc(1);
    end
    check("tmo_req", 32'(jump_req), 1);
    cyc(1023);
    check("tmo_still_launch", 32'(ctl_state), 3);
    cyc(1);
    check("tmo_idle", 32'(ctl_state), 0);
    check("tmo_power_held", 32'(jump_power), 5);
    cyc(5);

    // landing with space held must not re-charge until a fresh press
    base = n_jump;
    key_space = 1'b1;
    wait_state("rearm_charge", 3'd2, 40);
    key_space = 1'b0;
    wait_jumps("rearm_req", base + 1, 40);
    character_state = 2'b01;
    wait_state("rearm_air", 3'd4, 10);
    key_space = 1'b1;
    cyc(15);
    character_state = 2'b00;
    wait_state("rearm_land", 3'd0, 10);
    cyc(20);
    check("rearm_blocked", 32'(ctl_state), 0);
    key_space = 1'b0;
    cyc(12);
    do_jump("rearm_fresh", 3, 1'b0, 1'b0);

    // asynchronous reset mid-walk clears pulses and state immediately
    key_left = 1'b1;
    wait_state("ar_walk", 3'd1, 30);
    frame_tick = 1'b1;
    cyc(1);
    check("ar_step", 32'(step_left), 1);
    #2 rst = 1'b0;
    #1;
    check("ar_step_clr", 32'(step_left), 0);
    check("ar_state", 32'(ctl_state), 0);
    frame_tick = 1'b0;
    key_left = 1'b0;
    cyc(1);
    rst = 1'b1;
    cyc(12);

    check("pulse_rules", viol, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jump_input_ctl.md
Name: jump_input_ctl

Overview:
- Sequences keyboard intent into movement and jump commands for the character datapath (draw_rect_ctl).
- Synchronises and debounces space/left/right, then arbitrates them: jump has priority over walking, and keys are ignored while airborne.
- Counts jump charge per frame and issues a single jump_req carrying power and direction.
- Sits between the keyboard decoder and draw_rect_ctl; steps are gated to frame_tick.

Parameters:
PWR_W, 6, width of jump_power
MAX_POWER, 63, charge saturation value (must be < 2**PWR_W)
MIN_POWER, 4, floor applied to launched power
DEBOUNCE_CYC, 4, clk cycles a synchronised key must hold a new level before it is accepted
ACK_TIMEOUT, 1024, clk cycles LAUNCH waits for the airborne acknowledge

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
key_space  in  1  raw space level, asynchronous to clk
key_left  in  1  raw left level, asynchronous to clk
key_right  in  1  raw right level, asynchronous to clk
frame_tick  in  1  one-cycle pulse per frame
character_state  in  2  from datapath: 00 grounded, 01 rising, 10 falling, 11 treated as airborne
step_left  out  1  one-cycle step pulse
step_right  out  1  one-cycle step pulse
jump_req  out  1  one-cycle launch pulse
jump_power  out  PWR_W  launch power, stable from jump_req until the next CHARGE entry
jump_dir  out  2  00 vertical, 01 left, 10 right
charging  out  1  high in CHARGE
ctl_state  out  3  IDLE=0, WALK=1, CHARGE=2, LAUNCH=3, AIR=4

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; all outputs 0; debounced keys 0; charge counter 0; space_armed=1.
- Input conditioning: each key passes a 2-FF synchroniser, then a per-key counter. The debounced level changes only after DEBOUNCE_CYC consecutive cycles at the new level.
- Input latency: a clean edge reaches the debounced value 2+DEBOUNCE_CYC cycles after the raw edge. The FSM reacts on the following clk edge.
- dir_held: 01 if only left is held, 10 if only right is held, 00 if neither or both are held.
- IDLE:
  - Space held, space_armed=1 and character_state=00 -> CHARGE; the charge counter is cleared on entry.
  - Otherwise, dir_held != 00 and character_state=00 -> WALK.
  - Otherwise, character_state != 00 -> AIR.
- WALK:
  - On each frame_tick, pulse step_left or step_right per dir_held.
  - Space (armed) -> CHARGE; space wins over a simultaneous tick, so no step is emitted that cycle.
  - dir_held=00 -> IDLE. character_state != 00 -> AIR, e.g. walked off a ledge.
- CHARGE:
  - charging=1.
  - On each frame_tick, the counter increments, saturating at MAX_POWER.
  - jump_dir is updated from dir_held every cycle, so direction is latched at release.
  - Debounced space release -> LAUNCH.
  - character_state != 00 -> AIR with no jump issued; the counter is cleared.
- LAUNCH:
  - On the entry cycle, jump_req=1 for exactly one cycle and jump_power=max(counter, MIN_POWER).
  - Wait for character_state != 00, then -> AIR.
  - If ACK_TIMEOUT cycles pass without it, -> IDLE; jump_power is held.
- AIR:
  - All keys are ignored and no steps are emitted.
  - Every cycle in AIR, space_armed is cleared if space is currently held.
  - On character_state=00 -> IDLE.
- space_armed:
  - Cleared on LAUNCH entry.
  - Set whenever debounced space=0.
  - Prevents auto-rejump while space stays held through landing.
- Simultaneous events:
  - frame_tick in the same cycle as the release in CHARGE: the increment is applied before the power is captured.
  - Both directions held: vertical jump and no walking.
- Outputs are registered. step_*/jump_req never overlap and are never high for two consecutive cycles.
- Reset asserted mid-operation returns to IDLE immediately, with jump_req/steps forced to 0 asynchronously.

Optional Feature:
- JUMP_AUTO_RELEASE_EN defined: when the counter reaches MAX_POWER in CHARGE, the FSM moves to LAUNCH on the next cycle without a space release. space_armed is then cleared, so the held key does not recharge.
- Not defined: CHARGE holds at MAX_POWER until space is released.

Test Plan:
- Reset: rst=0 for 3 cycles, then release. Expect ctl_state=0, all outputs 0; space held from cycle 1 gives charging=1 at cycle 1+2+4+1=8.
- Raw key_space glitch 3 cycles wide (DEBOUNCE_CYC=4) -> ctl_state stays 0, charging never asserts.
- Space held for 10 frame_ticks with right held, then released -> one jump_req, jump_power=10, jump_dir=10. Drive character_state=01 -> ctl_state=4.
- Space held 2 ticks -> jump_power=4 (MIN_POWER). Space held 100 ticks -> jump_power=63; with JUMP_AUTO_RELEASE_EN, jump_req fires 1 cycle after the counter hits 63 while space is still held.
- Left held 5 frame_ticks while grounded -> exactly 5 step_left pulses. Then press left and right together -> no steps, ctl_state=0.
- LAUNCH with character_state held 00 for 1024 cycles -> return to IDLE. Land from AIR with space still held -> no new CHARGE until space has been released and pressed again.
